regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: port 0 is ALU writeback and port 1 is load writeback. Each port has a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains the slots into registered `write`/`wreg`/`wd` outputs that connect directly to the register file. A pending-write query tells the issue stage whether a source register still has a buffered or in-flight write.

---
 rtl/regfile_write_arbiter_pkg.sv | 16 +
 rtl/regfile_write_arbiter_if.sv | 66 ++++++
 rtl/rf_wr_slot.sv | 95 +++++++++
 rtl/regfile_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   RF_DATA_W / RF_ADDR_W : default write data / register address widths
//   RF_NUM_REQ            : number of writeback requesters sharing the port
//   arb_prio_e            : round-robin pointer, names the preferred port
package regfile_arb_pkg;

  localparam int unsigned RF_DATA_W  = 16;
  localparam int unsigned RF_ADDR_W  = 3;
  localparam int unsigned RF_NUM_REQ = 2;

  typedef enum logic [0:0] {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_prio_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of all arbiter-facing signals: two writeback request channels
// (valid/ready plus reg/data), the registered register-file write port,
// and the two pending-write query ports.
// Optional stall counters exist only when RF_ARB_STALL_CNT_EN is defined.
//   slave  : arbiter side (accepts requests, drives write port and query hits)
//   master : requester / register-file side
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = regfile_arb_pkg::RF_DATA_W,
  parameter int unsigned ADDR_WIDTH = regfile_arb_pkg::RF_ADDR_W
`ifdef RF_ARB_STALL_CNT_EN
  ,
  parameter int unsigned STALL_CNT_WIDTH = 8
`endif
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_reg;
  logic [DATA_WIDTH-1:0] req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_reg;
  logic [DATA_WIDTH-1:0] req1_data;

  logic                  write;
  logic [ADDR_WIDTH-1:0] wreg;
  logic [DATA_WIDTH-1:0] wd;

  logic [ADDR_WIDTH-1:0] qreg1;
  logic [ADDR_WIDTH-1:0] qreg2;
  logic                  pend1;
  logic                  pend2;

`ifdef RF_ARB_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall0;
  logic [STALL_CNT_WIDTH-1:0] stall1;
`endif

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    input  qreg1, qreg2,
    output req0_ready, req1_ready,
    output write, wreg, wd,
    output pend1, pend2
`ifdef RF_ARB_STALL_CNT_EN
    ,
    output stall0, stall1
`endif
  );

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    output qreg1, qreg2,
    input  req0_ready, req1_ready,
    input  write, wreg, wd,
    input  pend1, pend2
`ifdef RF_ARB_STALL_CNT_EN
    ,
    input  stall0, stall1
`endif
  );

endinterface

// File: rtl/rf_wr_slot.sv
// One-entry holding slot for a single writeback requester.
// Optional saturating stall counter when RF_ARB_STALL_CNT_EN is defined.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   valid/ready         : request handshake; ready = empty or being drained
//   in_reg, in_data     : incoming destination register and data
//   grant               : slot is being drained this cycle
//   full, slot_reg/data : slot contents, visible to arbiter and query logic
//   stall               : cycles spent with valid high and ready low
module rf_wr_slot #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
`ifdef RF_ARB_STALL_CNT_EN
  ,
  parameter int unsigned STALL_CNT_WIDTH = 8
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] in_reg,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  grant,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] slot_reg,
  output logic [DATA_WIDTH-1:0] slot_data
`ifdef RF_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall
`endif
);

  logic                  full_q, full_d;
  logic [ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept;

  // Ready never looks at valid, so there is no combinational loop back to
  // the requester; a slot being drained can refill in the same cycle.
  assign ready  = !full_q || grant;
  assign accept = valid && ready;

  always_comb begin
    full_d = full_q;
    reg_d  = reg_q;
    data_d = data_q;
    if (grant) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      reg_d  = in_reg;
      data_d = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign full      = full_q;
  assign slot_reg  = reg_q;
  assign slot_data = data_q;

`ifdef RF_ARB_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid && !ready && !(&stall_q)) begin
      stall_d = stall_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between ALU writeback
// (port 0) and load writeback (port 1). Each port buffers one write in an
// rf_wr_slot; a round-robin arbiter drains the slots into registered
// write/wreg/wd. A combinational query reports whether a register still has
// a buffered or in-flight write.
// Optional feature macro: RF_ARB_STALL_CNT_EN (per-port stall counters).
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   bus          : regfile_write_arbiter_if.slave (requests, write port, queries)
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = RF_DATA_W,
  parameter int unsigned ADDR_WIDTH      = RF_ADDR_W,
  parameter int unsigned STALL_CNT_WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  regfile_write_arbiter_if.slave bus
);

  if (DATA_WIDTH == 0 || ADDR_WIDTH == 0 || STALL_CNT_WIDTH == 0) begin : g_bad_param
    $error("regfile_write_arbiter: widths must be non-zero");
  end

  logic [RF_NUM_REQ-1:0] full;
  logic [RF_NUM_REQ-1:0] grant;
  logic [ADDR_WIDTH-1:0] slot_reg  [RF_NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data [RF_NUM_REQ];

  rf_wr_slot #(
    .DATA_WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH)
`ifdef RF_ARB_STALL_CNT_EN
    ,
    .STALL_CNT_WIDTH (STALL_CNT_WIDTH)
`endif
  ) u_slot0 (
    .clock     (clock),
    .reset     (reset),
    .valid     (bus.req0_valid),
    .ready     (bus.req0_ready),
    .in_reg    (bus.req0_reg),
    .in_data   (bus.req0_data),
    .grant     (grant[0]),
    .full      (full[0]),
    .slot_reg  (slot_reg[0]),
    .slot_data (slot_data[0])
`ifdef RF_ARB_STALL_CNT_EN
    ,
    .stall     (bus.stall0)
`endif
  );

  rf_wr_slot #(
    .DATA_WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH)
`ifdef RF_ARB_STALL_CNT_EN
    ,
    .STALL_CNT_WIDTH (STALL_CNT_WIDTH)
`endif
  ) u_slot1 (
    .clock     (clock),
    .reset     (reset),
    .valid     (bus.req1_valid),
    .ready     (bus.req1_ready),
    .in_reg    (bus.req1_reg),
    .in_data   (bus.req1_data),
    .grant     (grant[1]),
    .full      (full[1]),
    .slot_reg  (slot_reg[1]),
    .slot_data (slot_data[1])
`ifdef RF_ARB_STALL_CNT_EN
    ,
    .stall     (bus.stall1)
`endif
  );

  // Round-robin pointer: state register / next state / grant output.
  arb_prio_e prio_q, prio_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= PRI0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = PRI1;
    end else if (grant[1]) begin
      prio_d = PRI0;
    end
  end

  always_comb begin
    grant = '0;
    unique case (full)
      2'b00: grant = 2'b00;
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: grant = (prio_q == PRI0) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Output stage: registered strobe, address and data; address/data hold
  // their last values when idle.
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;

  always_comb begin
    write_d = |grant;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    if (grant[0]) begin
      wreg_d = slot_reg[0];
      wd_d   = slot_data[0];
    end else if (grant[1]) begin
      wreg_d = slot_reg[1];
      wd_d   = slot_data[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q <= 1'b0;
      wreg_q  <= '0;
      wd_q    <= '0;
    end else begin
      write_q <= write_d;
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.write = write_q;
  assign bus.wreg  = wreg_q;
  assign bus.wd    = wd_q;

  // Pending query covers both buffered writes and the one on the write port,
  // which the register file has not committed yet.
  logic pend1, pend2;

  always_comb begin
    pend1 = write_q && (wreg_q == bus.qreg1);
    pend2 = write_q && (wreg_q == bus.qreg2);
    for (int unsigned k = 0; k < RF_NUM_REQ; k++) begin
      pend1 = pend1 || (full[k] && (slot_reg[k] == bus.qreg1));
      pend2 = pend2 || (full[k] && (slot_reg[k] == bus.qreg2));
    end
  end

  assign bus.pend1 = pend1;
  assign bus.pend2 = pend2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed
// by randomized traffic, all compared against a transaction-level model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned SW = 2;
  localparam int          STALL_MAX = (1 << SW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  regfile_write_arbiter_if #(
`ifdef RF_ARB_STALL_CNT_EN
    .STALL_CNT_WIDTH (SW),
`endif
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW)
  ) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .STALL_CNT_WIDTH (SW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents of each port's buffer, who won last, and what
  // the write port is currently showing.
  bit            m_full  [2];
  logic [AW-1:0] m_reg   [2];
  logic [DW-1:0] m_data  [2];
  int            last_win;
  bit            m_write;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wd;
  int            m_stall [2];
  logic [DW-1:0] exp_rf  [8];
  logic [DW-1:0] dut_rf  [8];

  // Stimulus for the next cycle.
  bit            s_rst;
  bit            s_v [2];
  logic [AW-1:0] s_a [2];
  logic [DW-1:0] s_d [2];
  logic [AW-1:0] s_q1, s_q2;
  bit            acc [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [AW-1:0] q);
    return (m_full[0] && m_reg[0] == q) || (m_full[1] && m_reg[1] == q) ||
           (m_write && m_wreg == q);
  endfunction

  function automatic void reset_model();
    for (int k = 0; k < 2; k++) begin
      m_full[k]  = 1'b0;
      m_stall[k] = 0;
      acc[k]     = 1'b0;
    end
    last_win = 1;  // port 0 preferred first
    m_write  = 1'b0;
    m_wreg   = '0;
    m_wd     = '0;
  endfunction

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the model across the next rising edge.
  task automatic cycle();
    int win;
    bit r0, r1;
    @(negedge clock);
    reset          = s_rst;
    bus.req0_valid = s_v[0];
    bus.req0_reg   = s_a[0];
    bus.req0_data  = s_d[0];
    bus.req1_valid = s_v[1];
    bus.req1_reg   = s_a[1];
    bus.req1_data  = s_d[1];
    bus.qreg1      = s_q1;
    bus.qreg2      = s_q2;
    #1;
    win = -1;
    if (m_full[0] && m_full[1]) win = 1 - last_win;
    else if (m_full[0])         win = 0;
    else if (m_full[1])         win = 1;
    r0 = !m_full[0] || (win == 0);
    r1 = !m_full[1] || (win == 1);
    check("ready0", bus.req0_ready, r0);
    check("ready1", bus.req1_ready, r1);
    check("write",  bus.write, m_write);
    check("wreg",   bus.wreg, m_wreg);
    check("wd",     bus.wd, m_wd);
    check("pend1",  bus.pend1, hit(s_q1));
    check("pend2",  bus.pend2, hit(s_q2));
`ifdef RF_ARB_STALL_CNT_EN
    check("stall0", bus.stall0, m_stall[0]);
    check("stall1", bus.stall1, m_stall[1]);
`endif
    if (bus.write === 1'b1) dut_rf[bus.wreg] = bus.wd;
    if (m_write) exp_rf[m_wreg] = m_wd;
    if (s_rst) begin
      reset_model();
      s_v[0] = 1'b0;
      s_v[1] = 1'b0;
    end else begin
      if (s_v[0] && !r0 && m_stall[0] < STALL_MAX) m_stall[0]++;
      if (s_v[1] && !r1 && m_stall[1] < STALL_MAX) m_stall[1]++;
      if (win >= 0) begin
        m_write      = 1'b1;
        m_wreg       = m_reg[win];
        m_wd         = m_data[win];
        m_full[win]  = 1'b0;
        last_win     = win;
      end else begin
        m_write = 1'b0;
      end
      acc[0] = s_v[0] && r0;
      acc[1] = s_v[1] && r1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          m_full[k] = 1'b1;
          m_reg[k]  = s_a[k];
          m_data[k] = s_d[k];
        end
      end
    end
  endtask

  // New random request per port unless one is still waiting for ready.
  task automatic gen(input int pct);
    for (int k = 0; k < 2; k++) begin
      if (!(s_v[k] && !acc[k])) begin
        s_v[k] = ($urandom_range(99) < pct);
        s_a[k] = AW'($urandom_range(7));
        s_d[k] = DW'($urandom);
      end
    end
    s_q1 = AW'($urandom_range(7));
    s_q2 = AW'($urandom_range(7));
  endtask

  task automatic do_reset();
    s_rst  = 1'b1;
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    cycle();
    s_rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_v[k] = 1'b1;
    s_a[k] = a;
    s_d[k] = d;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      exp_rf[i] = '0;
      dut_rf[i] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      s_v[k] = 1'b0;
      s_a[k] = '0;
      s_d[k] = '0;
    end
    s_q1 = '0;
    s_q2 = '0;
    s_rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_reg = '0;
    bus.req1_reg = '0;
    bus.req0_data = '0;
    bus.req1_data = '0;
    bus.qreg1 = '0;
    bus.qreg2 = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    reset_model();

    // Single port-0 write, reg 3 / 0x1234, with a query tracking reg 3.
    s_q1 = 3'd3;
    s_q2 = 3'd6;
    set_req(0, 3'd3, 16'h1234);
    cycle();
    check("t1_ready0", bus.req0_ready, 1'b1);
    s_v[0] = 1'b0;
    cycle();
    check("t1_pend_slot", bus.pend1, 1'b1);
    cycle();
    check("t1_write", bus.write, 1'b1);
    check("t1_wreg", bus.wreg, 3'd3);
    check("t1_wd", bus.wd, 16'h1234);
    check("t1_pend_out", bus.pend1, 1'b1);
    cycle();
    check("t1_idle", bus.write, 1'b0);
    check("t1_pend_done", bus.pend1, 1'b0);

    // Simultaneous requests: port 0 first, then port 1.
    do_reset();
    set_req(0, 3'd1, 16'hAAAA);
    set_req(1, 3'd2, 16'h5555);
    cycle();
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    cycle();
    cycle();
    check("t2_first", bus.wd, 16'hAAAA);
    cycle();
    check("t2_second", bus.wd, 16'h5555);
    check("t2_wreg", bus.wreg, 3'd2);
    cycle();

    // Both ports streaming continuously.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      gen(100);
      cycle();
    end
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    repeat (3) cycle();

    // Same register from both ports with port 1 preferred.
    do_reset();
    set_req(0, 3'd0, 16'h0000);
    cycle();
    s_v[0] = 1'b0;
    repeat (3) cycle();
    set_req(0, 3'd5, 16'h0001);
    set_req(1, 3'd5, 16'h0002);
    cycle();
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    cycle();
    cycle();
    check("t4_first", bus.wd, 16'h0002);
    cycle();
    check("t4_second", bus.wd, 16'h0001);
    cycle();
    check("t4_final", dut_rf[5], 16'h0001);

    // Reset with both slots full discards them.
    do_reset();
    set_req(0, 3'd4, 16'hBEEF);
    set_req(1, 3'd7, 16'hCAFE);
    s_q1 = 3'd4;
    s_q2 = 3'd7;
    cycle();
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    s_rst  = 1'b1;
    cycle();
    s_rst = 1'b0;
    cycle();
    check("t5_write", bus.write, 1'b0);
    check("t5_ready0", bus.req0_ready, 1'b1);
    check("t5_ready1", bus.req1_ready, 1'b1);
    check("t5_pend1", bus.pend1, 1'b0);
    check("t5_pend2", bus.pend2, 1'b0);
    cycle();

`ifdef RF_ARB_STALL_CNT_EN
    // Contended streaming saturates the port-1 stall counter.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      gen(100);
      cycle();
    end
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    cycle();
    check("t6_stall1_sat", bus.stall1, STALL_MAX);
    repeat (2) cycle();
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gen(i < 1500 ? 60 : 90);
      s_rst = ($urandom_range(299) == 0);
      cycle();
      s_rst = 1'b0;
    end
    s_v[0] = 1'b0;
    s_v[1] = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rf%0d", i), dut_rf[i], exp_rf[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
